id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; sits directly downstream of the fetch stage.
- Owns the IF/ID pipeline register, the 32x32 register file and load-use/branch hazard detection.
- Resolves beq/bne/j in ID and returns Branch, Jump, JumpAddr and IFWrite to fetch.
- Consumes Instruction_if, PC and IF_flush; drives decoded operands and controls to EX.

Parameters:
- RF_DEPTH, 32, register count (r0 hard-wired 0)
- RESET_PC4, 32'h00000004, IF/ID PC+4 value after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Instruction_if  in  32  fetched instruction
- PC  in  32  address of Instruction_if
- IF_flush  in  1  ID slot holds wrong-path instruction; squash it
- RegWrite_ex, MemRead_ex  in  1 each  controls of instruction in EX
- WriteReg_ex  in  5  destination register in EX
- MemRead_mem  in  1  load in MEM
- WriteReg_mem  in  5  its destination
- RegWrite_wb  in  1  writeback enable
- WriteReg_wb  in  5  writeback register
- WriteData_wb  in  32  writeback data
- Branch, Jump  out  1 each  redirect fetch
- JumpAddr  out  32  redirect target
- IFWrite  out  1  0 = stall fetch and IF/ID
- RsData_id, RtData_id, Imm_id  out  32 each  operands, sign-extended immediate
- Rs_id, Rt_id, Rd_id  out  5 each  register fields
- Funct_id  out  6  instr[5:0]
- RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id  out  1 each  controls

Behaviour:
- Reset: IF/ID Instruction_id=0 (nop), PC4_id=RESET_PC4, all 32 registers cleared. All control outputs, Branch and Jump are 0; IFWrite=1.
- IF/ID: on clk edge with IFWrite=1, Instruction_id<=Instruction_if and PC4_id<=PC+4. With IFWrite=0 it holds.
- Squash: valid = !IF_flush. When invalid, all control outputs, Branch and Jump are 0, and no stall is raised.
- Register file: write on clk edge when RegWrite_wb and WriteReg_wb!=0. Reads are combinational with write-through: if the read address equals WriteReg_wb, RegWrite_wb=1 and the address is nonzero, return WriteData_wb. r0 always reads 0.
- Decode:
  - op 0x00: R-type; RegDst=1, RegWrite=1 unless the instruction is all-zero (nop).
  - 0x23 lw: MemRead, MemtoReg, ALUSrc, RegWrite.
  - 0x2B sw: MemWrite, ALUSrc.
  - 0x08 / 0x0C / 0x0D / 0x0A (addi/andi/ori/slti): ALUSrc, RegWrite.
  - 0x04 beq, 0x05 bne, 0x02 j: no EX controls.
  - Others: all 0.
- Imm_id = sign-extended instr[15:0] (zero-extended for andi/ori).
- Load-use stall: MemRead_ex and WriteReg_ex!=0 and WriteReg_ex matches Rs_id, or matches Rt_id for R-type/sw/beq/bne.
- Branch-operand stall for beq/bne only:
  - RegWrite_ex and WriteReg_ex!=0 matching Rs or Rt, or
  - MemRead_mem and WriteReg_mem!=0 matching Rs or Rt.
- stall = valid and (load-use or branch-operand).
  - IFWrite = !stall.
  - EX controls forced to 0 (bubble).
  - Branch and Jump forced to 0.
- Branch = valid & !stall & ((beq & RsData==RtData) | (bne & RsData!=RtData)).
- Jump = valid & !stall & j.
- JumpAddr:
  - Jump: {PC4_id[31:28], instr[25:0], 2'b00}.
  - Otherwise: PC4_id + (Imm_id<<2), 32-bit wrap.
- Latency: one cycle from fetch to decode outputs. Redirect is seen by fetch on the next edge; fetch raises IF_flush for exactly the following ID cycle.
- Reset mid-stall clears everything; no held instruction survives.

Decomposition:
- Shared package mips_defs:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI).
  - Field bit-positions.
  - Control-bundle struct.
- One sub-module: reg_file (2 read, 1 write, write-through, r0 zero).
- Hazard and decode logic stay inline.

Test Plan:
- Reset, then Instruction_if=0x2008000A (addi r8,r0,10), PC=0 -> next cycle Rt_id=8, Imm_id=10, ALUSrc_id=1, RegWrite_id=1, IFWrite=1.
- WB writes r9=0x55 in the same cycle ID reads r9 (R-type add r10,r9,r0) -> RsData_id=0x55; a write to r0 leaves it reading 0.
- ID holds add r3,r2,r1 while EX has lw r2 (MemRead_ex=1, WriteReg_ex=2) -> IFWrite=0, RegWrite_id=0, IF/ID holds. Next cycle with MemRead_ex=0 -> normal decode.
- beq r1,r1,+3 at PC=0x10 -> Branch=1, JumpAddr=0x20. Next cycle IF_flush=1 -> all controls 0 and Branch=0.
- j 0x0000040 at PC=0x1000 -> Jump=1, JumpAddr=0x100.
- bne r4,r5 while RegWrite_ex and WriteReg_ex=4 -> IFWrite=0, Branch=0. Next cycle MemRead_mem=1, WriteReg_mem=5 -> still stalled. Third cycle resolves, with Branch set per the operands.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions for the decode stage.
// Holds opcode constants, instruction field bit positions, the EX control
// bundle type and the opcode-to-control decoder used by id_stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction field bit positions.
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  // Raw EX controls for an instruction, before squash/stall gating.
  // The all-zero word is a nop and carries no controls.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    unique case (instr[OP_MSB:OP_LSB])
      OP_RTYPE: begin
        if (instr != 32'h0) begin
          c.reg_dst   = 1'b1;
          c.reg_write = 1'b1;
        end
      end
      OP_LW: begin
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.reg_write  = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational read ports, one write port.
// r0 reads as zero and ignores writes; a read of the register being
// written this cycle returns the incoming write data (write-through).
// Ports: clk, reset (sync, active-high), raddr_a_i/raddr_b_i read
// addresses, rdata_a_o/rdata_b_o read data, we_i/waddr_i/wdata_i write.
module reg_file #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] mem_q [RF_DEPTH];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  // NOTE: reset clears every register, so the whole array is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0)                ? 32'h0   :
                     (wr_en && (waddr_i == raddr_a_i))  ? wdata_i :
                                                          mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0)                ? 32'h0   :
                     (wr_en && (waddr_i == raddr_b_i))  ? wdata_i :
                                                          mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline.
// Owns the IF/ID register, the register file and hazard detection, and
// resolves beq/bne/j here, returning Branch/Jump/JumpAddr/IFWrite to fetch.
// Inputs: Instruction_if/PC from fetch, IF_flush squash, EX/MEM hazard
// info, WB write port. Outputs: redirect, fetch stall, operands, register
// fields, immediate, funct and EX controls.
module id_stage
  import mips_defs::*;
#(
  parameter int          RF_DEPTH  = 32,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC,
  input  logic        IF_flush,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        MemRead_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic        IFWrite,
  output logic [31:0] RsData_id,
  output logic [31:0] RtData_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs_id,
  output logic [4:0]  Rt_id,
  output logic [4:0]  Rd_id,
  output logic [5:0]  Funct_id,
  output logic        RegWrite_id,
  output logic        MemRead_id,
  output logic        MemWrite_id,
  output logic        MemtoReg_id,
  output logic        ALUSrc_id,
  output logic        RegDst_id
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  assign instr_d = Instruction_if;
  assign pc4_d   = PC + 32'd4;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc4_q   <= RESET_PC4;
    end else if (IFWrite) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  logic [5:0] opcode;
  assign opcode   = instr_q[OP_MSB:OP_LSB];
  assign Rs_id    = instr_q[RS_MSB:RS_LSB];
  assign Rt_id    = instr_q[RT_MSB:RT_LSB];
  assign Rd_id    = instr_q[RD_MSB:RD_LSB];
  assign Funct_id = instr_q[FUNCT_MSB:FUNCT_LSB];

  reg_file #(.RF_DEPTH(RF_DEPTH)) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (Rs_id),
    .raddr_b_i (Rt_id),
    .rdata_a_o (RsData_id),
    .rdata_b_o (RtData_id),
    .we_i      (RegWrite_wb),
    .waddr_i   (WriteReg_wb),
    .wdata_i   (WriteData_wb)
  );

  logic  valid, stall, is_beq, is_bne, is_j, uses_rt;
  logic  load_use, branch_haz;
  ctrl_t ctrl_raw, ctrl;

  assign valid    = !IF_flush;
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  // Only these formats actually read rt as a source operand.
  assign uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_beq || is_bne;
  assign ctrl_raw = decode_ctrl(instr_q);

  // NOTE: every signal written here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    Imm_id     = {{16{instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};
    load_use   = 1'b0;
    branch_haz = 1'b0;

    if ((opcode == OP_ANDI) || (opcode == OP_ORI))
      Imm_id = {16'h0, instr_q[IMM_MSB:IMM_LSB]};

    if (MemRead_ex && (WriteReg_ex != 5'd0))
      load_use = (WriteReg_ex == Rs_id) || (uses_rt && (WriteReg_ex == Rt_id));

    // Branches compare in ID, so any in-flight producer of either operand
    // that cannot be forwarded here holds the branch back.
    if (is_beq || is_bne) begin
      if (RegWrite_ex && (WriteReg_ex != 5'd0) &&
          ((WriteReg_ex == Rs_id) || (WriteReg_ex == Rt_id)))
        branch_haz = 1'b1;
      if (MemRead_mem && (WriteReg_mem != 5'd0) &&
          ((WriteReg_mem == Rs_id) || (WriteReg_mem == Rt_id)))
        branch_haz = 1'b1;
    end
  end

  assign stall   = valid && (load_use || branch_haz);
  assign IFWrite = !stall;
  assign ctrl    = (valid && !stall) ? ctrl_raw : '0;

  assign RegWrite_id = ctrl.reg_write;
  assign MemRead_id  = ctrl.mem_read;
  assign MemWrite_id = ctrl.mem_write;
  assign MemtoReg_id = ctrl.mem_to_reg;
  assign ALUSrc_id   = ctrl.alu_src;
  assign RegDst_id   = ctrl.reg_dst;

  assign Branch = valid && !stall &&
                  ((is_beq && (RsData_id == RtData_id)) ||
                   (is_bne && (RsData_id != RtData_id)));
  assign Jump   = valid && !stall && is_j;

  assign JumpAddr = is_j ? {pc4_q[31:28], instr_q[TGT_MSB:TGT_LSB], 2'b00}
                         : pc4_q + {Imm_id[29:0], 2'b00};

endmodule
